// File: rtl/chi_seq_pkg.sv
// Shared constants, FSM encoding and row helper for the masked chi row sequencer.
package chi_seq_pkg;

    localparam int ROW_W     = 5;
    localparam int NSHARES   = 3;
    localparam int MAX_ROWS  = 32;
    localparam int MAX_VEC_W = ROW_W * MAX_ROWS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Callers zero-extend their share vector to MAX_VEC_W so one helper serves any NROWS.
    function automatic logic [ROW_W-1:0] row_slice(input logic [MAX_VEC_W-1:0] vec, input int r);
        return vec[ROW_W*r +: ROW_W];
    endfunction

endpackage

// File: rtl/chi_row_sequencer_if.sv
// Row-level link between the sequencer and the three-share chi core.
interface chi_row_sequencer_if
    import chi_seq_pkg::*;
();

    logic [ROW_W-1:0] chi_in1;
    logic [ROW_W-1:0] chi_in2;
    logic [ROW_W-1:0] chi_in3;
    logic [ROW_W-1:0] chi_out1;
    logic [ROW_W-1:0] chi_out2;
    logic [ROW_W-1:0] chi_out3;

    modport master (
        output chi_in1, chi_in2, chi_in3,
        input  chi_out1, chi_out2, chi_out3
    );

    modport slave (
        input  chi_in1, chi_in2, chi_in3,
        output chi_out1, chi_out2, chi_out3
    );

endinterface

// File: rtl/chi_seq_delay.sv
// Shift register carrying {valid, row index} alongside the chi core pipeline.
module chi_seq_delay #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             feed_vld,
    input  logic [IDX_W-1:0] feed_idx,
    output logic             cap_vld,
    output logic [IDX_W-1:0] cap_idx
);

    logic             vld_p [DEPTH];
    logic [IDX_W-1:0] idx_p [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_p[i] <= 1'b0;
                idx_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= feed_vld;
            idx_p[0] <= feed_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
                idx_p[i] <= idx_p[i-1];
            end
        end
    end

    assign cap_vld = vld_p[DEPTH-1];
    assign cap_idx = idx_p[DEPTH-1];

endmodule

// File: rtl/chi_row_sequencer.sv
// Feeds a 3-share state row by row into the registered chi core and collects the result rows.
module chi_row_sequencer
    import chi_seq_pkg::*;
#(
    parameter int NROWS    = 5,
    parameter int CORE_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ROW_W*NROWS-1:0] state1_i,
    input  logic [ROW_W*NROWS-1:0] state2_i,
    input  logic [ROW_W*NROWS-1:0] state3_i,
    chi_row_sequencer_if.master    chi,
    output logic [ROW_W*NROWS-1:0] state1_o,
    output logic [ROW_W*NROWS-1:0] state2_o,
    output logic [ROW_W*NROWS-1:0] state3_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int VEC_W = ROW_W * NROWS;
    localparam int RD_W  = $clog2(NROWS + 1);

    seq_state_e       state_q, state_d;
    logic [RD_W-1:0]  rd_q;
    logic [VEC_W-1:0] in1_q, in2_q, in3_q;
    logic [VEC_W-1:0] res1_q, res2_q, res3_q;
    logic             busy_q, done_q;
    logic             feeding, load;
    logic             cap_vld;
    logic [RD_W-1:0]  cap_idx;

    assign feeding = (state_q == FEED);
    assign load    = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FEED;
            FEED:    if (rd_q == RD_W'(NROWS - 1)) state_d = DRAIN;
            DRAIN:   if (cap_vld && (cap_idx == RD_W'(NROWS - 1))) state_d = DONE;
            DONE:    state_d = start_i ? FEED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == FEED) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
        end
    end

    // Share k is only ever muxed with share k; outside FEED the core sees zeros.
    always_comb begin
        chi.chi_in1 = '0;
        chi.chi_in2 = '0;
        chi.chi_in3 = '0;
        if (feeding) begin
            chi.chi_in1 = row_slice(MAX_VEC_W'(in1_q), int'(rd_q));
            chi.chi_in2 = row_slice(MAX_VEC_W'(in2_q), int'(rd_q));
            chi.chi_in3 = row_slice(MAX_VEC_W'(in3_q), int'(rd_q));
        end
    end

    chi_seq_delay #(
        .DEPTH (CORE_LAT),
        .IDX_W (RD_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst_i),
        .feed_vld (feeding),
        .feed_idx (rd_q),
        .cap_vld  (cap_vld),
        .cap_idx  (cap_idx)
    );

    // rd saturates at NROWS once the last row is issued, until the next load.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_q   <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            in3_q  <= '0;
            res1_q <= '0;
            res2_q <= '0;
            res3_q <= '0;
        end else begin
            if (load) begin
                rd_q  <= '0;
                in1_q <= state1_i;
                in2_q <= state2_i;
                in3_q <= state3_i;
            end else if (feeding && (rd_q != RD_W'(NROWS))) begin
                rd_q <= rd_q + RD_W'(1);
            end
            if (cap_vld) begin
                res1_q[ROW_W*int'(cap_idx) +: ROW_W] <= chi.chi_out1;
                res2_q[ROW_W*int'(cap_idx) +: ROW_W] <= chi.chi_out2;
                res3_q[ROW_W*int'(cap_idx) +: ROW_W] <= chi.chi_out3;
            end
        end
    end

    assign state1_o = res1_q;
    assign state2_o = res2_q;
    assign state3_o = res3_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_chi_row_sequencer.sv
// Bench for chi_row_sequencer: one-stage (dut_a) and two-stage (dut_b) threshold chi core models.
module tb_chi_row_sequencer;
    import chi_seq_pkg::*;

    localparam int NR = 5;
    localparam int VW = 25;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_a, start_b;
    logic [VW-1:0] state1_i, state2_i, state3_i;
    logic [VW-1:0] r1_a, r2_a, r3_a, r1_b, r2_b, r3_b;
    logic          busy_a, done_a, busy_b, done_b;
    int            total = 0;
    int            bad   = 0;

    chi_row_sequencer_if ifa();
    chi_row_sequencer_if ifb();

    always #5 clk = ~clk;

    chi_row_sequencer #(.NROWS(NR), .CORE_LAT(1)) dut_a (
        .clk(clk), .rst_i(rst_i), .start_i(start_a),
        .state1_i(state1_i), .state2_i(state2_i), .state3_i(state3_i),
        .chi(ifa),
        .state1_o(r1_a), .state2_o(r2_a), .state3_o(r3_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    chi_row_sequencer #(.NROWS(NR), .CORE_LAT(2)) dut_b (
        .clk(clk), .rst_i(rst_i), .start_i(start_b),
        .state1_i(state1_i), .state2_i(state2_i), .state3_i(state3_i),
        .chi(ifb),
        .state1_o(r1_b), .state2_o(r2_b), .state3_o(r3_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    // Unmasked reference: y[i] = x[i] ^ (~x[i+1] & x[i+2]), indices mod 5.
    function automatic logic [4:0] chi_row(input logic [4:0] x);
        logic [4:0] y;
        for (int i = 0; i < 5; i++) y[i] = x[i] ^ (~x[(i+1)%5] & x[(i+2)%5]);
        return y;
    endfunction

    function automatic logic [VW-1:0] chi_state(input logic [VW-1:0] x);
        logic [VW-1:0] y;
        for (int r = 0; r < NR; r++) y[5*r +: 5] = chi_row(x[5*r +: 5]);
        return y;
    endfunction

    // Non-complete share function of the threshold chi; output share k uses the other two shares.
    function automatic logic [4:0] ti_row(input logic [4:0] b, input logic [4:0] c);
        logic [4:0] y;
        for (int i = 0; i < 5; i++)
            y[i] = b[i] ^ (~b[(i+1)%5] & b[(i+2)%5]) ^ (b[(i+1)%5] & c[(i+2)%5]) ^ (c[(i+1)%5] & b[(i+2)%5]);
        return y;
    endfunction

    function automatic logic [VW-1:0] ti_state(input logic [VW-1:0] b, input logic [VW-1:0] c);
        logic [VW-1:0] y;
        for (int r = 0; r < NR; r++) y[5*r +: 5] = ti_row(b[5*r +: 5], c[5*r +: 5]);
        return y;
    endfunction

    always @(posedge clk) begin
        ifa.chi_out1 <= ti_row(ifa.chi_in2, ifa.chi_in3);
        ifa.chi_out2 <= ti_row(ifa.chi_in3, ifa.chi_in1);
        ifa.chi_out3 <= ti_row(ifa.chi_in1, ifa.chi_in2);
    end

    logic [4:0] cb1_p0, cb2_p0, cb3_p0;
    always @(posedge clk) begin
        cb1_p0 <= ti_row(ifb.chi_in2, ifb.chi_in3);
        cb2_p0 <= ti_row(ifb.chi_in3, ifb.chi_in1);
        cb3_p0 <= ti_row(ifb.chi_in1, ifb.chi_in2);
        ifb.chi_out1 <= cb1_p0;
        ifb.chi_out2 <= cb2_p0;
        ifb.chi_out3 <= cb3_p0;
    end

    task automatic run_dut(input int sel, input logic [VW-1:0] s1, input logic [VW-1:0] s2,
                           input logic [VW-1:0] s3, output int done_at, output int n_done,
                           output int busy_err);
        int lat_total;
        logic bsy, dn;
        lat_total = (sel == 0) ? NR + 2 : NR + 3;
        @(negedge clk);
        state1_i = s1; state2_i = s2; state3_i = s3;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0; start_b = 1'b0;
        done_at = -1; n_done = 0; busy_err = 0;
        for (int k = 1; k <= lat_total + 2; k++) begin
            @(negedge clk);
            bsy = (sel == 0) ? busy_a : busy_b;
            dn  = (sel == 0) ? done_a : done_b;
            if (dn === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (bsy !== (k < lat_total)) busy_err++;
        end
    endtask

    task automatic test_reset();
        total++; if (r1_a !== '0) begin bad++; $display("FAIL reset_r1_a got=%h exp=0", r1_a); end
        total++; if (r2_a !== '0) begin bad++; $display("FAIL reset_r2_a got=%h exp=0", r2_a); end
        total++; if (r3_a !== '0) begin bad++; $display("FAIL reset_r3_a got=%h exp=0", r3_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done_a got=%b exp=0", done_a); end
        total++; if ({ifa.chi_in1, ifa.chi_in2, ifa.chi_in3} !== 15'd0) begin
            bad++; $display("FAIL reset_chi_in_a got=%h exp=0", {ifa.chi_in1, ifa.chi_in2, ifa.chi_in3}); end
        total++; if ({r1_b, r2_b, r3_b, busy_b, done_b} !== '0) begin
            bad++; $display("FAIL reset_b got=%h exp=0", {r1_b, r2_b, r3_b, busy_b, done_b}); end
    endtask

    task automatic test_zero();
        int da, nd, be;
        run_dut(0, '0, '0, '0, da, nd, be);
        total++; if (da !== 7) begin bad++; $display("FAIL zero_done_at got=%0d exp=7", da); end
        total++; if (nd !== 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", nd); end
        total++; if (be !== 0) begin bad++; $display("FAIL zero_busy_profile got=%0d errs exp=0", be); end
        total++; if ((r1_a ^ r2_a ^ r3_a) !== '0) begin
            bad++; $display("FAIL zero_result got=%h exp=0", r1_a ^ r2_a ^ r3_a); end
    endtask

    task automatic test_ones();
        logic [VW-1:0] x, s1, s2, s3, f1, f2, f3;
        logic v1, v2, v3;
        int da, nd, be;
        x = '1; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        for (int n = 0; n < 100; n++) begin
            s1 = VW'($urandom); s2 = VW'($urandom); s3 = x ^ s1 ^ s2;
            run_dut(0, s1, s2, s3, da, nd, be);
            total++; if ((r1_a ^ r2_a ^ r3_a) !== x) begin
                bad++; $display("FAIL ones_result run=%0d got=%h exp=%h", n, r1_a ^ r2_a ^ r3_a, x); end
            if (n == 0) begin f1 = r1_a; f2 = r2_a; f3 = r3_a; end
            else begin
                if (r1_a !== f1) v1 = 1'b1;
                if (r2_a !== f2) v2 = 1'b1;
                if (r3_a !== f3) v3 = 1'b1;
            end
        end
        total++; if (v1 !== 1'b1) begin bad++; $display("FAIL ones_share1_varies got=%b exp=1", v1); end
        total++; if (v2 !== 1'b1) begin bad++; $display("FAIL ones_share2_varies got=%b exp=1", v2); end
        total++; if (v3 !== 1'b1) begin bad++; $display("FAIL ones_share3_varies got=%b exp=1", v3); end
    endtask

    task automatic test_random();
        logic [VW-1:0] x, s1, s2, s3;
        int da, nd, be;
        for (int n = 0; n < 1000; n++) begin
            x = VW'($urandom); s1 = VW'($urandom); s2 = VW'($urandom); s3 = x ^ s1 ^ s2;
            run_dut(0, s1, s2, s3, da, nd, be);
            total++; if ((r1_a ^ r2_a ^ r3_a) !== chi_state(x)) begin
                bad++; $display("FAIL rand_result run=%0d got=%h exp=%h", n, r1_a ^ r2_a ^ r3_a, chi_state(x)); end
            total++; if (r1_a !== ti_state(s2, s3)) begin
                bad++; $display("FAIL rand_share1 run=%0d got=%h exp=%h", n, r1_a, ti_state(s2, s3)); end
            total++; if (r2_a !== ti_state(s3, s1)) begin
                bad++; $display("FAIL rand_share2 run=%0d got=%h exp=%h", n, r2_a, ti_state(s3, s1)); end
            total++; if (r3_a !== ti_state(s1, s2)) begin
                bad++; $display("FAIL rand_share3 run=%0d got=%h exp=%h", n, r3_a, ti_state(s1, s2)); end
            total++; if (da !== 7 || nd !== 1 || be !== 0) begin
                bad++; $display("FAIL rand_timing run=%0d got=done_at %0d count %0d busy_errs %0d exp=7 1 0", n, da, nd, be); end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] v1 [5];
        logic [VW-1:0] v2 [5];
        logic [VW-1:0] v3 [5];
        logic [VW-1:0] x;
        int run, ph;
        for (int j = 0; j < 5; j++) begin
            v1[j] = VW'($urandom); v2[j] = VW'($urandom); v3[j] = VW'($urandom);
        end
        @(negedge clk);
        state1_i = v1[0]; state2_i = v2[0]; state3_i = v3[0];
        start_a = 1'b1;
        @(posedge clk);
        run = 0;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            ph = ((c - 1) % 7) + 1;
            total++; if (done_a !== (ph == 7)) begin
                bad++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", c, done_a, ph == 7); end
            total++; if (busy_a !== (ph != 7)) begin
                bad++; $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", c, busy_a, ph != 7); end
            if (ph == 7) begin
                x = v1[run] ^ v2[run] ^ v3[run];
                total++; if ((r1_a ^ r2_a ^ r3_a) !== chi_state(x)) begin
                    bad++; $display("FAIL b2b_result run=%0d got=%h exp=%h", run, r1_a ^ r2_a ^ r3_a, chi_state(x)); end
                total++; if (r1_a !== ti_state(v2[run], v3[run])) begin
                    bad++; $display("FAIL b2b_share1 run=%0d got=%h exp=%h", run, r1_a, ti_state(v2[run], v3[run])); end
                run++;
                if (run < 4) begin
                    state1_i = v1[run]; state2_i = v2[run]; state3_i = v3[run];
                end else begin
                    start_a = 1'b0;
                end
            end else begin
                state1_i = VW'($urandom); state2_i = VW'($urandom); state3_i = VW'($urandom);
            end
        end
        @(negedge clk);
        total++; if ({busy_a, done_a} !== 2'b00) begin
            bad++; $display("FAIL b2b_stop got=%b exp=00", {busy_a, done_a}); end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] x, s1, s2, s3;
        int nd, da, be;
        x = VW'($urandom); s1 = VW'($urandom); s2 = VW'($urandom); s3 = x ^ s1 ^ s2;
        @(negedge clk);
        state1_i = s1; state2_i = s2; state3_i = s3; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_i = 1'b1;
        #1;
        total++; if ({r1_a, r2_a, r3_a} !== '0) begin
            bad++; $display("FAIL midrst_results got=%h exp=0", {r1_a, r2_a, r3_a}); end
        total++; if ({busy_a, done_a} !== 2'b00) begin
            bad++; $display("FAIL midrst_flags got=%b exp=00", {busy_a, done_a}); end
        total++; if ({ifa.chi_in1, ifa.chi_in2, ifa.chi_in3} !== 15'd0) begin
            bad++; $display("FAIL midrst_chi_in got=%h exp=0", {ifa.chi_in1, ifa.chi_in2, ifa.chi_in3}); end
        #1 rst_i = 1'b0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) nd++;
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d active cycles exp=0", nd); end
        total++; if ({r1_a, r2_a, r3_a} !== '0) begin
            bad++; $display("FAIL midrst_hold got=%h exp=0", {r1_a, r2_a, r3_a}); end
        x = VW'($urandom); s1 = VW'($urandom); s2 = VW'($urandom); s3 = x ^ s1 ^ s2;
        run_dut(0, s1, s2, s3, da, nd, be);
        total++; if ((r1_a ^ r2_a ^ r3_a) !== chi_state(x) || da !== 7) begin
            bad++; $display("FAIL midrst_clean_run got=%h at %0d exp=%h at 7", r1_a ^ r2_a ^ r3_a, da, chi_state(x)); end
    endtask

    task automatic test_lat2();
        logic [VW-1:0] x, s1, s2, s3, rc, gx;
        int da, nd, be;
        for (int r = 0; r < NR; r++) x[5*r +: 5] = 5'($urandom_range(1, 31));
        s1 = VW'($urandom); s2 = VW'($urandom); s3 = x ^ s1 ^ s2;
        gx = chi_state(x);
        @(negedge clk);
        state1_i = s1; state2_i = s2; state3_i = s3; start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rc = r1_b ^ r2_b ^ r3_b;
            for (int r = 0; r < NR; r++) begin
                if (k == r + 3) begin
                    total++; if (rc[5*r +: 5] !== 5'd0) begin
                        bad++; $display("FAIL lat2_early row=%0d got=%h exp=0", r, rc[5*r +: 5]); end
                end
                if (k == r + 4) begin
                    total++; if (rc[5*r +: 5] !== gx[5*r +: 5]) begin
                        bad++; $display("FAIL lat2_capture row=%0d got=%h exp=%h", r, rc[5*r +: 5], gx[5*r +: 5]); end
                end
            end
            total++; if (done_b !== (k == 8)) begin
                bad++; $display("FAIL lat2_done cycle=%0d got=%b exp=%b", k, done_b, k == 8); end
            total++; if (busy_b !== (k < 8)) begin
                bad++; $display("FAIL lat2_busy cycle=%0d got=%b exp=%b", k, busy_b, k < 8); end
        end
        for (int n = 0; n < 20; n++) begin
            x = VW'($urandom); s1 = VW'($urandom); s2 = VW'($urandom); s3 = x ^ s1 ^ s2;
            run_dut(1, s1, s2, s3, da, nd, be);
            total++; if ((r1_b ^ r2_b ^ r3_b) !== chi_state(x) || r3_b !== ti_state(s1, s2)) begin
                bad++; $display("FAIL lat2_rand run=%0d got=%h exp=%h", n, r1_b ^ r2_b ^ r3_b, chi_state(x)); end
            total++; if (da !== 8 || nd !== 1 || be !== 0) begin
                bad++; $display("FAIL lat2_timing run=%0d got=done_at %0d count %0d busy_errs %0d exp=8 1 0", n, da, nd, be); end
        end
    endtask

    initial begin
        rst_i = 1'b1; start_a = 1'b0; start_b = 1'b0;
        state1_i = '0; state2_i = '0; state3_i = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_i = 1'b0;
        test_zero();
        test_ones();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_lat2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chi_row_sequencer.md
Name: chi_row_sequencer

Overview:
- Drives a 3-share masked Keccak-f[25] state (5 rows × 5 bits per share) through the first-order-registered, fresh-randomness-free chi core. Sits directly upstream of that core and also collects its output.
- Feeds one row per cycle, drains the core's pipeline, writes each result row into output share registers, then pulses done.
- The core is instantiated beside this block and connects only through the chi_* ports.

Parameters:
- NROWS, 5, number of 5-bit rows per share.
- CORE_LAT, 1, register latency of the chi core in cycles (≥1).

Ports:
- clk  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  begin processing; sampled only while busy_o=0
- state1_i / state2_i / state3_i  in  5*NROWS each  input shares; row r = bits [5r+4:5r]
- chi_in1 / chi_in2 / chi_in3  out  5 each  row shares to the core
- chi_out1 / chi_out2 / chi_out3  in  5 each  row shares from the core
- state1_o / state2_o / state3_o  out  5*NROWS each  result shares, same row layout as the inputs
- busy_o  out  1  high from the cycle after start is accepted until done
- done_o  out  1  one-cycle pulse; state*_o are complete

Behaviour:
- Reset is asynchronous and active-high on rst_i, clocked by clk. Reset state:
  - FSM in IDLE.
  - All share registers, result registers and counters at 0.
  - chi_in* = 0, busy_o = 0, done_o = 0.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - On the edge E0 where start_i=1, copy state*_i into the input share registers.
  - Set feed counter rd=0 and go to FEED.
- FEED:
  - chi_in* = row rd of each input share register.
  - rd increments each edge.
  - After row NROWS-1 is presented, go to DRAIN.
  - Row r is therefore consumed by the core at edge E(r+1).
- Capture alignment:
  - A valid/index delay line of depth CORE_LAT tracks each fed row.
  - Row r's result is written into row r of the result registers at edge E(r+1+CORE_LAT).
  - The three shares are captured in the same cycle, with no cross-share recombination anywhere.
- DRAIN:
  - chi_in* = 0.
  - Leave DRAIN once the last row is captured at edge E(NROWS+CORE_LAT), then enter DONE.
- DONE:
  - done_o=1 for exactly one cycle.
  - busy_o=0 in this cycle.
  - Next state is IDLE, or FEED if start_i=1 in this cycle (back-to-back accept with a fresh load of state*_i).
- busy_o:
  - Registered output.
  - 1 in FEED and DRAIN; 0 in IDLE and DONE.
- Masking rules:
  - chi_in* is driven to 0 whenever not in FEED, so no stale share data reaches the core.
  - Share k only ever mixes with share k in muxes.
  - Input and result registers are separate; the register index never selects across shares.
- state*_o:
  - Driven from the result registers.
  - Hold their last value until the next capture. Partially updated rows are visible during a run; only the done_o cycle guarantees consistency.
- start_i while busy_o=1 is ignored and has no latched effect.
- rst_i mid-run: immediate return to IDLE.
  - All registers, including the results, clear.
  - No done_o is produced.
  - In-flight core data is discarded, because the delay line clears.
- Latency from the start-accept edge E0 to done_o high is NROWS+CORE_LAT+1 cycles; the defaults give 7.
- Arithmetic:
  - rd is sized to $clog2(NROWS+1).
  - The capture index comes from the delay line, not recomputed.
  - No wrap: rd saturates at NROWS until the next start.

Decomposition:
- Package chi_seq_pkg holds:
  - ROW_W=5 and NSHARES=3;
  - the state encoding IDLE/FEED/DRAIN/DONE;
  - a row-slice helper function for index r.
- One sub-module, chi_seq_delay: a CORE_LAT-deep shift register carrying {valid, row index}. It has an asynchronous active-high reset and is reused for capture alignment.

Test Plan:
- All shares 0 → every row of the recombined state1_o^state2_o^state3_o is 0. done_o pulses exactly 7 cycles after the start-accept edge; busy_o is high for cycles 1–6.
- Unmasked rows of 5'h1F, randomly 3-way split → recombined output rows all 5'h1F. Each individual output share is not constant across 100 random splits.
- Random state plus random masks over 1000 runs → recombined output equals the golden unmasked Keccak chi applied row-wise.
- start_i held high through a run → exactly one run per accept. Back-to-back starts taken in the done_o cycle give a done_o every 7 cycles with correct results each time.
- rst_i pulsed at cycle 3 of a run → all outputs 0 in the same cycle, with no done_o. A following clean run is correct.
- CORE_LAT=2 with a 2-stage core model → done_o at cycle 8. Row r is captured at edge E(r+3), and results are correct.
